mode_applier: RTL

//  Consumer end of the dipswitch mode interface.

---
 rtl/mode_applier_if.sv | 33 +++
 rtl/mode_applier.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mode_applier_if.sv
// Mode hand-off bus between the testbench/system side and mode_applier.
// Signals:
//   mode_in       requested 2-bit mode (2'b00 invalid)
//   capture_idle  capture path halted acknowledge
//   fault_clr     single-cycle clear of the sticky fault flag
//   stop_req      halt request to the capture path
//   active_mode   mode currently applied
//   sample_div    sample divider for the applied mode
//   mode_changed  one-cycle pulse when a new mode takes effect
//   busy          high while a mode switch is in progress
//   fault         sticky: last switch was forced by timeout
// Modports: master drives the requests/acks, slave is the mode_applier.
interface mode_applier_if;
    logic [1:0]  mode_in;
    logic        capture_idle;
    logic        fault_clr;
    logic        stop_req;
    logic [1:0]  active_mode;
    logic [15:0] sample_div;
    logic        mode_changed;
    logic        busy;
    logic        fault;

    modport master (
        output mode_in, capture_idle, fault_clr,
        input  stop_req, active_mode, sample_div, mode_changed, busy, fault
    );

    modport slave (
        input  mode_in, capture_idle, fault_clr,
        output stop_req, active_mode, sample_div, mode_changed, busy, fault
    );
endinterface

// File: rtl/mode_applier.sv
// Consumer end of the dipswitch mode interface.
// Qualifies a new mode word as stable, halts the capture path, waits for its
// idle acknowledge (or a timeout), then loads the new active mode and sample
// divider and releases the capture path.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    mode_applier_if.slave (mode_in/capture_idle/fault_clr in,
//          stop_req/active_mode/sample_div/mode_changed/busy/fault out)
module mode_applier #(
    parameter int unsigned STABLE_CYCLES = 4096,
    parameter int unsigned TIMEOUT       = 65535,
    parameter logic [15:0] DIV_M1        = 16'd1,
    parameter logic [15:0] DIV_M2        = 16'd10,
    parameter logic [15:0] DIV_M3        = 16'd100
) (
    input  logic           clk,
    input  logic           rst_n,
    mode_applier_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_STOP    = 2'd2,
        ST_APPLY   = 2'd3
    } state_t;

    state_t             r_state;
    logic [1:0]         r_cand;
    logic [CNT_W-1:0]   r_cnt;
    logic [TMO_W-1:0]   r_tmo;
    logic               r_stop_req;
    logic [1:0]         r_active_mode;
    logic [15:0]        r_sample_div;
    logic               r_mode_changed;
    logic               r_busy;
    logic               r_fault;

    state_t             w_state_nxt;
    logic [1:0]         w_cand_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [TMO_W-1:0]   w_tmo_nxt;
    logic [1:0]         w_active_nxt;
    logic [15:0]        w_div_nxt;
    logic               w_fault_nxt;
    logic               w_fault_set;
    logic               w_mode_valid;

    // Divider that belongs to a given mode; 2'b00 never becomes a candidate.
    function automatic logic [15:0] div_for_mode(input logic [1:0] mode);
        logic [15:0] div;
        case (mode)
            2'b01:   div = DIV_M1;
            2'b10:   div = DIV_M2;
            2'b11:   div = DIV_M3;
            default: div = DIV_M3;
        endcase
        return div;
    endfunction

    assign w_mode_valid = (bus.mode_in != 2'b00);

    // Next-state, qualification/timeout counters and applied-mode selection.
    always_comb begin
        w_state_nxt  = r_state;
        w_cand_nxt   = r_cand;
        w_cnt_nxt    = r_cnt;
        w_tmo_nxt    = r_tmo;
        w_active_nxt = r_active_mode;
        w_div_nxt    = r_sample_div;
        w_fault_set  = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_mode_valid && (bus.mode_in != r_active_mode)) begin
                    w_cand_nxt  = bus.mode_in;
                    w_cnt_nxt   = CNT_W'(1);
                    w_state_nxt = ST_QUALIFY;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_QUALIFY: begin
                if (bus.mode_in == r_cand) begin
                    if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
                        w_state_nxt = ST_STOP;
                        w_tmo_nxt   = TMO_W'(0);
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else if (!w_mode_valid || (bus.mode_in == r_active_mode)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    // A different valid value restarts qualification on that value.
                    w_cand_nxt = bus.mode_in;
                    w_cnt_nxt  = CNT_W'(1);
                end
            end
            ST_STOP: begin
                // Candidate is frozen here; mode_in is not looked at.
                if (bus.capture_idle) begin
                    w_state_nxt = ST_APPLY;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_APPLY;
                    w_fault_set = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            ST_APPLY: begin
                w_state_nxt  = ST_RUN;
                w_active_nxt = r_cand;
                w_div_nxt    = div_for_mode(r_cand);
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // Timeout set takes priority over a simultaneous clear.
        if (w_fault_set) begin
            w_fault_nxt = 1'b1;
        end else if (bus.fault_clr) begin
            w_fault_nxt = 1'b0;
        end else begin
            w_fault_nxt = r_fault;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_cand         <= 2'b00;
            r_cnt          <= CNT_W'(0);
            r_tmo          <= TMO_W'(0);
            r_stop_req     <= 1'b0;
            r_active_mode  <= 2'b11;
            r_sample_div   <= DIV_M3;
            r_mode_changed <= 1'b0;
            r_busy         <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cand         <= w_cand_nxt;
            r_cnt          <= w_cnt_nxt;
            r_tmo          <= w_tmo_nxt;
            // Outputs are registered from the next state so they line up with it.
            r_stop_req     <= (w_state_nxt == ST_STOP) || (w_state_nxt == ST_APPLY);
            r_active_mode  <= w_active_nxt;
            r_sample_div   <= w_div_nxt;
            r_mode_changed <= (r_state == ST_APPLY);
            r_busy         <= (w_state_nxt != ST_RUN);
            r_fault        <= w_fault_nxt;
        end
    end

    assign bus.stop_req     = r_stop_req;
    assign bus.active_mode  = r_active_mode;
    assign bus.sample_div   = r_sample_div;
    assign bus.mode_changed = r_mode_changed;
    assign bus.busy         = r_busy;
    assign bus.fault        = r_fault;

endmodule
